ddc_frame_sender: RTL and testbench

DDC_FRAME_SENDER -- requirements
Module: ddc_frame_sender

---
 rtl/ddc_frame_sender.sv | 211 +++++++++++++++++++++
 tb/tb_ddc_frame_sender.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_frame_sender.sv
// Purpose : round-robin packetiser that frames one DDC channel's FIFO bytes behind a 16-byte header for the UDP layer.
// Latency : one arbitration cycle, then request; byte 0 is valid while waiting for udp_tx_enable, and each active cycle advances one byte.
// Backpr. : udp_tx_active gates every byte advance and FIFO read; a stall watchdog aborts a frame that makes no progress for TIMEOUT cycles.
//
// Ports:
//   tx_clock, reset_n             clock and async active-low reset (release synchronised internally)
//   run, fifo_ready, rx_data      streaming enable, per-channel frame flags and FIFO read data (8 bits per channel)
//   samples_per_frame, time_stamp per-channel frame size (16 bits per channel) and free-running timestamp
//   udp_tx_enable, udp_tx_active  UDP grant and per-byte consume strobe
//   udp_tx_request/_length/_data  frame request, payload length and current byte
//   port_ID, fifo_rdreq           source-port offset and per-channel FIFO read strobe
//   phy_ready, timeout_err        idle-with-nothing-pending flag and watchdog abort pulse
module ddc_frame_sender #(
    parameter int NR              = 8,
    parameter int MAX_SPF         = 238,
    parameter int BITS_PER_SAMPLE = 24,
    parameter int BASE_PORT       = 11,
    parameter int TIMEOUT         = 250000000
) (
    input  logic              tx_clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic [NR-1:0]     fifo_ready,
    input  logic [8*NR-1:0]   rx_data,
    input  logic [16*NR-1:0]  samples_per_frame,
    input  logic [63:0]       time_stamp,
    input  logic              udp_tx_enable,
    input  logic              udp_tx_active,
    output logic              udp_tx_request,
    output logic [15:0]       udp_tx_length,
    output logic [7:0]        udp_tx_data,
    output logic [7:0]        port_ID,
    output logic [NR-1:0]     fifo_rdreq,
    output logic              phy_ready,
    output logic              timeout_err
);
    localparam int SW = (NR > 1) ? $clog2(NR) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] BPS = 16'(BITS_PER_SAMPLE);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_SEND, S_DONE} state_t;

    // Assertion is immediate; release is delayed two clocks so every flop leaves reset on the same edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d, ptr_q, ptr_d;
    logic [15:0]     spf_q, spf_d, len_q, len_d, byte_q, byte_d;
    logic [63:0]     ts_q, ts_d;
    logic [7:0]      port_q, port_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            tmo_q, tmo_d;
    logic [31:0]     seq_q [NR];
    logic            seq_inc, seq_clr;

    // Single-cycle round-robin search starting at the channel after the last grant.
    logic            gnt_found;
    logic [SW-1:0]   gnt_ch, ptr_next;
    logic [15:0]     gnt_spf_raw, gnt_spf;
    int              idx;
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = ptr_q;
        idx       = 0;
        for (int i = 0; i < NR; i++) begin
            idx = (int'(ptr_q) + i) % NR;
            if (!gnt_found && fifo_ready[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = SW'(idx);
            end
        end
        gnt_spf_raw = samples_per_frame[int'(gnt_ch)*16 +: 16];
        gnt_spf     = (gnt_spf_raw > 16'(MAX_SPF)) ? 16'(MAX_SPF) : gnt_spf_raw;
        ptr_next    = SW'((int'(gnt_ch) + 1) % NR);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        spf_d   = spf_q;
        len_d   = len_q;
        byte_d  = byte_q;
        ts_d    = ts_q;
        port_d  = port_q;
        wd_d    = wd_q;
        tmo_d   = 1'b0;
        seq_inc = 1'b0;
        seq_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                wd_d   = '0;
                byte_d = '0;
                if (!run)              seq_clr = 1'b1;
                else if (|fifo_ready)  state_d = S_ARB;
            end
            S_ARB: begin
                if (!gnt_found) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d   = gnt_ch;
                    spf_d   = gnt_spf;
                    ts_d    = time_stamp;
                    len_d   = 16'd16 + 16'd6 * gnt_spf;
                    port_d  = 8'(BASE_PORT + int'(gnt_ch));
                    ptr_d   = ptr_next;
                    // A zero-sample channel is passed over without ever raising a request.
                    state_d = (gnt_spf == 16'd0) ? S_IDLE : S_REQ;
                end
            end
            S_REQ: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (udp_tx_enable) begin
                    state_d = S_SEND;
                    wd_d    = '0;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_SEND: begin
                if (udp_tx_active) begin
                    wd_d   = '0;
                    byte_d = byte_q + 16'd1;
                    // Leave on the edge that consumes the last byte so the request drops right after it.
                    if (byte_q == len_q - 16'd1) begin
                        state_d = S_DONE;
                        seq_inc = 1'b1;
                    end
                end else if (udp_tx_enable) begin
                    wd_d = '0;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            spf_q   <= '0;
            len_q   <= '0;
            byte_q  <= '0;
            ts_q    <= '0;
            port_q  <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            for (int i = 0; i < NR; i++) seq_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            spf_q   <= spf_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            ts_q    <= ts_d;
            port_q  <= port_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
            if (seq_clr) begin
                for (int i = 0; i < NR; i++) seq_q[i] <= '0;
            end else if (seq_inc) begin
                seq_q[sel_q] <= seq_q[sel_q] + 32'd1;
            end
        end
    end

    // Reads run one byte ahead of the payload because the FIFO returns data a cycle after the strobe.
    logic rd_win;
    int   bn;
    assign rd_win = (state_q == S_SEND) && udp_tx_active &&
                    (byte_q >= 16'd15) && (byte_q <= len_q - 16'd2);
    assign fifo_rdreq = rd_win ? (NR'(1) << sel_q) : '0;

    always_comb begin
        udp_tx_data = 8'h00;
        bn          = int'(byte_q);
        if (udp_tx_request) begin
            if (bn < 4)        udp_tx_data = seq_q[sel_q][8*(3-bn) +: 8];
            else if (bn < 12)  udp_tx_data = ts_q[8*(11-bn) +: 8];
            else if (bn == 12) udp_tx_data = BPS[15:8];
            else if (bn == 13) udp_tx_data = BPS[7:0];
            else if (bn == 14) udp_tx_data = spf_q[15:8];
            else if (bn == 15) udp_tx_data = spf_q[7:0];
            else               udp_tx_data = rx_data[int'(sel_q)*8 +: 8];
        end
    end

    assign udp_tx_request = (state_q == S_REQ) || (state_q == S_SEND);
    assign udp_tx_length  = len_q;
    assign port_ID        = port_q;
    assign timeout_err    = tmo_q;
    assign phy_ready      = (state_q == S_IDLE) && (fifo_ready == '0);
endmodule

// File: tb/tb_ddc_frame_sender.sv
module tb_ddc_frame_sender;
    localparam int NR   = 4;
    localparam int TMO  = 100;
    localparam int MAXS = 238;

    logic              tx_clock = 1'b0;
    logic              reset_n, run, udp_tx_enable, udp_tx_active;
    logic [NR-1:0]     fifo_ready;
    logic [8*NR-1:0]   rx_data;
    logic [16*NR-1:0]  samples_per_frame;
    logic [63:0]       time_stamp;
    logic              udp_tx_request, phy_ready, timeout_err;
    logic [15:0]       udp_tx_length;
    logic [7:0]        udp_tx_data, port_ID;
    logic [NR-1:0]     fifo_rdreq;

    ddc_frame_sender #(.NR(NR), .TIMEOUT(TMO)) dut (
        .tx_clock(tx_clock), .reset_n(reset_n), .run(run), .fifo_ready(fifo_ready),
        .rx_data(rx_data), .samples_per_frame(samples_per_frame), .time_stamp(time_stamp),
        .udp_tx_enable(udp_tx_enable), .udp_tx_active(udp_tx_active),
        .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data),
        .port_ID(port_ID), .fifo_rdreq(fifo_rdreq), .phy_ready(phy_ready), .timeout_err(timeout_err)
    );

    always #5 tx_clock = ~tx_clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int c, input int k);
        return 8'(c * 61 + k * 13 + 5);
    endfunction

    // Channel FIFOs: registered read data, one-cycle latency, each read returns the next pattern byte.
    logic [7:0] fq   [NR] = '{default: 8'h00};
    int         rcnt [NR] = '{default: 0};
    always @(posedge tx_clock) begin
        for (int c = 0; c < NR; c++) begin
            if (fifo_rdreq[c]) begin
                fq[c]   <= pat(c, rcnt[c]);
                rcnt[c] <= rcnt[c] + 1;
            end
        end
    end
    for (genvar g = 0; g < NR; g++) begin : g_rx
        assign rx_data[8*g +: 8] = fq[g];
    end

    // Reference model: expected frames as header info plus a flat byte stream.
    typedef struct packed {
        logic [7:0]  ch;
        logic [15:0] len;
        logic [7:0]  port;
        logic [15:0] spf;
    } finfo_t;
    finfo_t      exp_info  [$];
    logic [7:0]  exp_bytes [$];
    logic [31:0] mseq  [NR] = '{default: 32'd0};
    int          mrcnt [NR] = '{default: 0};
    int          mptr = 0;

    function automatic int eff_spf(input int c);
        int s;
        s = int'(samples_per_frame[16*c +: 16]);
        return (s > MAXS) ? MAXS : s;
    endfunction

    function automatic void push_frame(input int c);
        int s;
        finfo_t f;
        s      = eff_spf(c);
        f.ch   = 8'(c);
        f.len  = 16'(16 + 6 * s);
        f.port = 8'(11 + c);
        f.spf  = 16'(s);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(mseq[c][8*i +: 8]);
        for (int i = 7; i >= 0; i--) exp_bytes.push_back(time_stamp[8*i +: 8]);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'd24);
        exp_bytes.push_back(8'(s >> 8));
        exp_bytes.push_back(8'(s));
        for (int k = 0; k < 6 * s; k++) exp_bytes.push_back(pat(c, mrcnt[c] + k));
        mrcnt[c] = mrcnt[c] + 6 * s;
        mseq[c]  = mseq[c] + 32'd1;
        exp_info.push_back(f);
    endfunction

    // Predict the next n real frames for a held ready mask; zero-sample channels are passed over.
    function automatic void predict(input logic [NR-1:0] mask, input int n);
        int got, guard, c;
        logic found;
        got = 0;
        guard = 0;
        while (got < n && guard < 64) begin
            guard++;
            found = 1'b0;
            c = 0;
            for (int i = 0; i < NR; i++) begin
                if (!found && mask[(mptr + i) % NR]) begin
                    found = 1'b1;
                    c = (mptr + i) % NR;
                end
            end
            if (!found) begin
                guard = 64;
            end else begin
                mptr = (c + 1) % NR;
                if (eff_spf(c) != 0) begin
                    push_frame(c);
                    got++;
                end
            end
        end
    endfunction

    // UDP-side driver: 0 = active held high, 1 = random active, 2 = toggling active, 3 = never grants.
    int mode = 1;
    int st = 0;
    int dly = 0;
    always @(posedge tx_clock) begin
        #1;
        if (!reset_n) begin
            st = 0;
            udp_tx_enable = 1'b0;
            udp_tx_active = 1'b0;
        end else if (st == 0) begin
            udp_tx_enable = 1'b0;
            udp_tx_active = 1'b0;
            if (udp_tx_request && mode != 3) begin
                if (dly == 0) begin
                    udp_tx_enable = 1'b1;
                    st = 1;
                end else begin
                    dly--;
                end
            end
        end else begin
            udp_tx_enable = 1'b0;
            if (!udp_tx_request) begin
                st = 0;
                udp_tx_active = 1'b0;
                dly = $urandom_range(0, 3);
            end else begin
                case (mode)
                    0:       udp_tx_active = 1'b1;
                    2:       udp_tx_active = ~udp_tx_active;
                    default: udp_tx_active = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever a byte is consumed.
    int     byte_idx = 0, frame_rd = 0, frames_done = 0;
    int     req_run = 0, last_req_run = 0, tmo_run = 0, last_tmo_run = 0, tmo_pulses = 0;
    logic   in_frame = 1'b0, bogus = 1'b0;
    finfo_t cur = '0;
    always @(negedge tx_clock) begin
        if (!reset_n) begin
            byte_idx = 0;
            frame_rd = 0;
            in_frame = 1'b0;
            bogus    = 1'b0;
            chk("rdreq_in_reset", 64'(fifo_rdreq), 64'd0);
        end else begin
            if (udp_tx_request) req_run++;
            else if (req_run > 0) begin
                last_req_run = req_run;
                req_run = 0;
            end
            if (timeout_err) begin
                if (tmo_run == 0) tmo_pulses++;
                tmo_run++;
            end else if (tmo_run > 0) begin
                last_tmo_run = tmo_run;
                tmo_run = 0;
            end
            if (!udp_tx_request) bogus = 1'b0;
            if (fifo_rdreq != '0) begin
                frame_rd++;
                chk("rdreq_onehot", 64'(fifo_rdreq), 64'(1) << cur.ch);
            end
            if (udp_tx_request && udp_tx_active) begin
                if (!in_frame) begin
                    if (exp_info.size() == 0) begin
                        if (!bogus) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_frame: got port %0d length %0d expected no frame", port_ID, udp_tx_length);
                        end
                        bogus = 1'b1;
                    end else begin
                        cur = exp_info.pop_front();
                        in_frame = 1'b1;
                        byte_idx = 0;
                        chk($sformatf("ch%0d_length", cur.ch), 64'(udp_tx_length), 64'(cur.len));
                        chk($sformatf("ch%0d_port", cur.ch), 64'(port_ID), 64'(cur.port));
                    end
                end
                if (in_frame) begin
                    if (exp_bytes.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL byte_underflow: got %0h expected nothing", udp_tx_data);
                    end else begin
                        chk($sformatf("ch%0d_byte%0d", cur.ch, byte_idx), 64'(udp_tx_data), 64'(exp_bytes.pop_front()));
                    end
                    byte_idx++;
                    if (byte_idx == int'(cur.len)) begin
                        chk($sformatf("ch%0d_rdreq_count", cur.ch), 64'(frame_rd), 64'(6 * int'(cur.spf)));
                        frame_rd = 0;
                        byte_idx = 0;
                        in_frame = 1'b0;
                        frames_done++;
                    end
                end
            end
        end
    end

    task automatic wait_done(input int tgt);
        int cyc;
        cyc = 0;
        while (frames_done < tgt && cyc < 8000) begin
            @(negedge tx_clock);
            cyc++;
        end
        fifo_ready = '0;
        if (frames_done < tgt) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_wait: got %0d frames expected %0d", frames_done, tgt);
            exp_info.delete();
            exp_bytes.delete();
        end
        repeat (4) @(negedge tx_clock);
        chk("queue_drained", 64'(exp_info.size() + exp_bytes.size()), 64'd0);
        chk("phy_ready_idle", 64'(phy_ready), 64'd1);
    endtask

    task automatic run_frames(input logic [NR-1:0] mask, input int n);
        int tgt;
        tgt = frames_done + n;
        time_stamp = {$urandom, $urandom};
        predict(mask, n);
        fifo_ready = mask;
        wait_done(tgt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_request"}, 64'(udp_tx_request), 64'd0);
        chk({tag, "_length"},  64'(udp_tx_length),  64'd0);
        chk({tag, "_data"},    64'(udp_tx_data),    64'd0);
        chk({tag, "_port"},    64'(port_ID),        64'd0);
        chk({tag, "_rdreq"},   64'(fifo_rdreq),     64'd0);
        chk({tag, "_tmo"},     64'(timeout_err),    64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc, rq, t0, r100, tgt;
        run = 1'b0;
        fifo_ready = '0;
        samples_per_frame = '0;
        time_stamp = '0;
        udp_tx_enable = 1'b0;
        udp_tx_active = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        chk("reset_phy_ready", 64'(phy_ready), 64'd1);
        repeat (3) @(negedge tx_clock);
        reset_n = 1'b1;
        repeat (4) @(negedge tx_clock);
        run = 1'b1;

        // Single channel 2 with two samples, active held high: 28-byte frame on port 13.
        samples_per_frame[16*2 +: 16] = 16'd2;
        mode = 0;
        run_frames(4'b0100, 1);

        // Sequence clear while stopped, then all channels ready over eight frames.
        run = 1'b0;
        repeat (3) @(negedge tx_clock);
        for (int c = 0; c < NR; c++) mseq[c] = 32'd0;
        run = 1'b1;
        for (int c = 0; c < NR; c++) samples_per_frame[16*c +: 16] = 16'($urandom_range(1, 12));
        mode = 1;
        run_frames(4'b1111, 8);

        // Oversized request clamps to the maximum; a zero-sample channel is skipped.
        samples_per_frame[16*0 +: 16] = 16'd1000;
        samples_per_frame[16*1 +: 16] = 16'd0;
        mode = 0;
        run_frames(4'b0011, 2);

        // Only the zero-sample channel ready: no request ever appears.
        fifo_ready = 4'b0010;
        rq = 0;
        repeat (30) begin
            @(negedge tx_clock);
            if (udp_tx_request) rq++;
        end
        chk("skip_no_request", 64'(rq), 64'd0);
        chk("phy_ready_pending", 64'(phy_ready), 64'd0);
        fifo_ready = '0;
        mptr = 2;
        repeat (3) @(negedge tx_clock);

        // Watchdog: no grant for TIMEOUT cycles aborts, the retry carries the same sequence number.
        samples_per_frame[16*2 +: 16] = 16'd3;
        time_stamp = {$urandom, $urandom};
        predict(4'b0100, 1);
        tgt = frames_done + 1;
        t0 = tmo_pulses;
        mode = 3;
        fifo_ready = 4'b0100;
        cyc = 0;
        while (tmo_pulses == t0 && cyc < 500) begin
            @(negedge tx_clock);
            cyc++;
        end
        r100 = last_req_run;
        mode = 1;
        chk("timeout_seen", 64'(tmo_pulses), 64'(t0 + 1));
        chk("timeout_request_cycles", 64'(r100), 64'(TMO));
        fifo_ready = 4'b0100;
        wait_done(tgt);
        chk("timeout_pulse_width", 64'(last_tmo_run), 64'd1);
        chk("timeout_single_pulse", 64'(tmo_pulses), 64'(t0 + 1));

        // Toggling active: data only advances on active cycles.
        samples_per_frame[16*0 +: 16] = 16'd5;
        mode = 2;
        run_frames(4'b0001, 1);

        // Run dropped while requesting abandons the frame.
        samples_per_frame[16*3 +: 16] = 16'd2;
        mode = 3;
        fifo_ready = 4'b1000;
        cyc = 0;
        while (!udp_tx_request && cyc < 50) begin
            @(negedge tx_clock);
            cyc++;
        end
        chk("abandon_request_seen", 64'(udp_tx_request), 64'd1);
        run = 1'b0;
        fifo_ready = '0;
        @(negedge tx_clock);
        chk("abandon_request_dropped", 64'(udp_tx_request), 64'd0);
        mptr = 0;
        for (int c = 0; c < NR; c++) mseq[c] = 32'd0;
        repeat (2) @(negedge tx_clock);
        run = 1'b1;
        mode = 1;
        repeat (2) @(negedge tx_clock);

        // Reset mid-frame at byte 20; afterwards channel 0 is granted first with sequence 0.
        samples_per_frame[16*1 +: 16] = 16'd10;
        mode = 0;
        time_stamp = {$urandom, $urandom};
        predict(4'b0010, 1);
        fifo_ready = 4'b0010;
        cyc = 0;
        while (byte_idx < 20 && cyc < 200) begin
            @(negedge tx_clock);
            cyc++;
        end
        chk("reset_mid_reached", 64'(byte_idx >= 20), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        fifo_ready = '0;
        exp_info.delete();
        exp_bytes.delete();
        repeat (3) @(negedge tx_clock);
        for (int c = 0; c < NR; c++) begin
            mseq[c]  = 32'd0;
            mrcnt[c] = rcnt[c];
        end
        mptr = 0;
        reset_n = 1'b1;
        repeat (4) @(negedge tx_clock);
        for (int c = 0; c < NR; c++) samples_per_frame[16*c +: 16] = 16'($urandom_range(1, 8));
        mode = 1;
        run_frames(4'b1111, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
